debug_strip_sequencer: RTL and testbench

//  Debug-side controller that serves a data request from the MicroBlaze/MIPS debug interface.
//  It decodes the 6-bit request_select ID and sequences the register-file, PC, data/instr memory
//  or pipeline-latch reads. It then streams a fixed-length strip of 32-bit frames onto the

---
 rtl/debug_strip_sequencer.sv | 142 ++++++++++++++
 tb/tb_debug_strip_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_strip_sequencer.sv
// Debug-side request sequencer: decodes a request ID, reads the selected MIPS state source,
// and streams a fixed-length strip of frames followed by a one-cycle end-of-data pulse.
module debug_strip_sequencer #(
  parameter int NB_FRAME    = 32,
  parameter int NB_SEL      = 6,
  parameter int NB_ADDR     = 16,
  parameter int NB_REG_ADDR = 5,
  parameter int N_LATCH     = 8,
  parameter int STRIP_WORDS = 3
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic [NB_SEL-1:0]                     i_request_select,
  input  logic [NB_ADDR-1:0]                    i_mem_addr,
  output logic [NB_REG_ADDR-1:0]                o_reg_addr,
  input  logic [NB_FRAME-1:0]                   i_reg_data,
  input  logic [NB_FRAME-1:0]                   i_pc,
  output logic [NB_ADDR-1:0]                    o_mem_addr,
  output logic                                  o_mem_rd_en,
  output logic                                  o_instr_rd_en,
  input  logic [NB_FRAME-1:0]                   i_mem_data,
  input  logic [NB_FRAME-1:0]                   i_instr_data,
  input  logic [N_LATCH*STRIP_WORDS*NB_FRAME-1:0] i_latch_data,
  output logic [NB_FRAME-1:0]                   o_frame,
  output logic                                  o_frame_valid,
  output logic                                  o_eod,
  output logic                                  o_busy,
  output logic                                  o_req_dropped
);

  localparam int NB_STRIP = STRIP_WORDS * NB_FRAME;
  localparam int NB_CNT   = $clog2(STRIP_WORDS + 1);
  localparam int NB_LIDX  = (N_LATCH > 1) ? $clog2(N_LATCH) : 1;

  localparam logic [NB_SEL-1:0] SEL_NONE   = '1;
  localparam logic [NB_SEL-1:0] SEL_DMEM   = NB_SEL'(32);
  localparam logic [NB_SEL-1:0] SEL_IMEM   = NB_SEL'(33);
  localparam logic [NB_SEL-1:0] SEL_PC     = NB_SEL'(34);
  localparam logic [NB_SEL-1:0] LATCH_BASE = NB_SEL'(36);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, STREAM, EOD} state_t;

  state_t                state_q, state_d;
  logic [NB_SEL-1:0]     reqSel_q, reqSel_d;
  logic [NB_ADDR-1:0]    reqAddr_q, reqAddr_d;
  logic [NB_STRIP-1:0]   strip_q, strip_d;
  logic [NB_CNT-1:0]     wordCnt_q, wordCnt_d;
  logic                  dropped_q, dropped_d;

  logic [NB_STRIP-1:0]   latchGroups [N_LATCH];
  logic [NB_STRIP-1:0]   stripLoad;
  logic [NB_SEL-1:0]     latchOff;
  logic                  isReg;
  logic                  isLatch;

  for (genvar k = 0; k < N_LATCH; k++) begin : g_latch
    assign latchGroups[k] = i_latch_data[k*NB_STRIP +: NB_STRIP];
  end

  assign isReg    = ~reqSel_q[NB_SEL-1];
  assign latchOff = reqSel_q - LATCH_BASE;
  assign isLatch  = (reqSel_q >= LATCH_BASE) && (latchOff < NB_SEL'(N_LATCH));

  // Single-word sources land in the most significant word so they stream out first.
  always_comb begin
    stripLoad = '0;
    if (isReg)
      stripLoad = NB_STRIP'(i_reg_data) << (NB_STRIP - NB_FRAME);
    else if (reqSel_q == SEL_DMEM)
      stripLoad = NB_STRIP'(i_mem_data) << (NB_STRIP - NB_FRAME);
    else if (reqSel_q == SEL_IMEM)
      stripLoad = NB_STRIP'(i_instr_data) << (NB_STRIP - NB_FRAME);
    else if (reqSel_q == SEL_PC)
      stripLoad = NB_STRIP'(i_pc) << (NB_STRIP - NB_FRAME);
    else if (isLatch)
      stripLoad = latchGroups[latchOff[NB_LIDX-1:0]];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      reqSel_q  <= '0;
      reqAddr_q <= '0;
      strip_q   <= '0;
      wordCnt_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reqSel_q  <= reqSel_d;
      reqAddr_q <= reqAddr_d;
      strip_q   <= strip_d;
      wordCnt_q <= wordCnt_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reqSel_d  = reqSel_q;
    reqAddr_d = reqAddr_q;
    strip_d   = strip_q;
    wordCnt_d = wordCnt_q;
    dropped_d = (state_q != IDLE) && (i_request_select != SEL_NONE);
    case (state_q)
      IDLE: begin
        if (i_request_select != SEL_NONE) begin
          reqSel_d  = i_request_select;
          reqAddr_d = i_mem_addr;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        strip_d   = stripLoad;
        wordCnt_d = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        strip_d = strip_q << NB_FRAME;
        if (wordCnt_q == NB_CNT'(STRIP_WORDS - 1)) begin
          wordCnt_d = '0;
          state_d   = EOD;
        end else begin
          wordCnt_d = wordCnt_q + 1'b1;
        end
      end
      EOD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_busy        = (state_q != IDLE);
  assign o_frame_valid = (state_q == STREAM);
  assign o_frame       = o_frame_valid ? strip_q[NB_STRIP-1 -: NB_FRAME] : '0;
  assign o_eod         = (state_q == EOD);
  assign o_mem_rd_en   = (state_q == LOAD) && (reqSel_q == SEL_DMEM);
  assign o_instr_rd_en = (state_q == LOAD) && (reqSel_q == SEL_IMEM);
  assign o_reg_addr    = isReg ? reqSel_q[NB_REG_ADDR-1:0] : '0;
  assign o_mem_addr    = reqAddr_q;
  assign o_req_dropped = dropped_q;

endmodule

// File: tb/tb_debug_strip_sequencer.sv
// Scoreboard bench for debug_strip_sequencer: stimulus queues expected frames and EoD pulses,
// a negedge monitor pops and compares them with cycle-accurate timing.
module tb_debug_strip_sequencer;

  localparam int NB_STRIP = 96;
  localparam int N_LATCH  = 8;
  localparam logic [5:0] SEL_IDLE = 6'b111111;

  logic                         i_clock = 1'b0;
  logic                         i_reset;
  logic [5:0]                   i_request_select;
  logic [15:0]                  i_mem_addr;
  logic [4:0]                   o_reg_addr;
  logic [31:0]                  regData;
  logic [31:0]                  pcVal;
  logic [15:0]                  o_mem_addr;
  logic                         o_mem_rd_en;
  logic                         o_instr_rd_en;
  logic [31:0]                  memData;
  logic [31:0]                  instrData;
  logic [N_LATCH*NB_STRIP-1:0]  latchData;
  logic [31:0]                  o_frame;
  logic                         o_frame_valid;
  logic                         o_eod;
  logic                         o_busy;
  logic                         o_req_dropped;

  typedef struct {
    int          cycle;
    bit          isEod;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;

  debug_strip_sequencer dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_request_select (i_request_select),
    .i_mem_addr       (i_mem_addr),
    .o_reg_addr       (o_reg_addr),
    .i_reg_data       (regData),
    .i_pc             (pcVal),
    .o_mem_addr       (o_mem_addr),
    .o_mem_rd_en      (o_mem_rd_en),
    .o_instr_rd_en    (o_instr_rd_en),
    .i_mem_data       (memData),
    .i_instr_data     (instrData),
    .i_latch_data     (latchData),
    .o_frame          (o_frame),
    .o_frame_valid    (o_frame_valid),
    .o_eod            (o_eod),
    .o_busy           (o_busy),
    .o_req_dropped    (o_req_dropped)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Simple source models with one-cycle read latency; stale reads return poison values.
  assign pcVal = 32'h0040_0000 + 32'(cyc) * 4;

  always @(posedge i_clock) begin
    regData   <= (o_reg_addr == 5'd5) ? 32'hDEADBEEF : {4{3'b000, o_reg_addr}};
    memData   <= o_mem_rd_en ? (32'h12345678 ^ {16'h0, o_mem_addr ^ 16'h0040}) : 32'hBAD0BAD0;
    instrData <= o_instr_rd_en ? (32'hCAFE0000 | {16'h0, o_mem_addr}) : 32'hBAD1BAD1;
  end

  function automatic logic [31:0] latchWord(input int k, input int w);
    if (k == 4) return (w == 0) ? 32'h11111111 : (w == 1) ? 32'h22222222 : 32'h33333333;
    return 32'hA0000000 | 32'(k << 4) | 32'(w);
  endfunction

  initial begin
    for (int k = 0; k < N_LATCH; k++)
      for (int w = 0; w < 3; w++)
        latchData[k*NB_STRIP + (2-w)*32 +: 32] = latchWord(k, w);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
  endtask

  always @(negedge i_clock) begin
    exp_t e;
    if (o_frame_valid || o_eod) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousOutput", {30'b0, o_eod, o_frame_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        checkOutput("frameCycle", 32'(cyc), 32'(e.cycle));
        checkOutput("frameKind", {30'b0, o_eod, o_frame_valid}, e.isEod ? 32'h2 : 32'h1);
        checkOutput("frameData", o_frame, e.data);
      end
    end else begin
      checkOutput("idleFrameZero", o_frame, 32'h0);
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] sel, input logic [15:0] addr,
                               input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input int nWords, input bit withEod);
    logic [31:0] words [3];
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    i_request_select = sel;
    i_mem_addr       = addr;
    for (int i = 0; i < nWords; i++) sb.push_back('{cyc + 3 + i, 1'b0, words[i]});
    if (withEod) sb.push_back('{cyc + 6, 1'b1, 32'h0});
  endtask

  task automatic requestAndRelease(input logic [5:0] sel, input logic [15:0] addr,
                                   input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    applyStimulus(sel, addr, w0, w1, w2, 3, 1'b1);
    tick();
    i_request_select = SEL_IDLE;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (o_busy && n < 20) begin
      @(negedge i_clock);
      n++;
    end
    if (o_busy) checkOutput("idleTimeout", 32'h1, 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_request_select = SEL_IDLE;
    i_mem_addr = 16'h0;
    repeat (3) tick();
    @(negedge i_clock);
    checkOutput("resetBusy", {31'b0, o_busy}, 32'h0);
    checkOutput("resetStrobes", {27'b0, o_frame_valid, o_eod, o_mem_rd_en, o_instr_rd_en, o_req_dropped}, 32'h0);
    checkOutput("resetRegAddr", {27'b0, o_reg_addr}, 32'h0);
    checkOutput("resetMemAddr", {16'b0, o_mem_addr}, 32'h0);
    tick();
    i_reset = 1'b0;
    tick();

    requestAndRelease(6'b000101, 16'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    @(negedge i_clock);
    checkOutput("regAddrT1", {27'b0, o_reg_addr}, 32'd5);
    checkOutput("regBusyT1", {31'b0, o_busy}, 32'h1);
    checkOutput("regNoMemRd", {30'b0, o_mem_rd_en, o_instr_rd_en}, 32'h0);
    waitIdle();

    requestAndRelease(6'b100000, 16'h0040, 32'h12345678, 32'h0, 32'h0);
    @(negedge i_clock);
    checkOutput("memRdEnT1", {30'b0, o_mem_rd_en, o_instr_rd_en}, 32'h2);
    checkOutput("memAddrT1", {16'b0, o_mem_addr}, 32'h0040);
    tick();
    @(negedge i_clock);
    checkOutput("memRdEnT2", {31'b0, o_mem_rd_en}, 32'h0);
    waitIdle();

    requestAndRelease(6'b100001, 16'h0010, 32'hCAFE0010, 32'h0, 32'h0);
    @(negedge i_clock);
    checkOutput("instrRdEnT1", {30'b0, o_mem_rd_en, o_instr_rd_en}, 32'h1);
    waitIdle();

    requestAndRelease(6'b100010, 16'h0, 32'h0040_0000 + 32'(cyc + 2) * 4, 32'h0, 32'h0);
    waitIdle();

    requestAndRelease(6'b101000, 16'h0, latchWord(4, 0), latchWord(4, 1), latchWord(4, 2));
    waitIdle();
    requestAndRelease(6'b100100, 16'h0, latchWord(0, 0), latchWord(0, 1), latchWord(0, 2));
    waitIdle();
    requestAndRelease(6'b101011, 16'h0, latchWord(7, 0), latchWord(7, 1), latchWord(7, 2));
    waitIdle();

    requestAndRelease(6'b110000, 16'h0, 32'h0, 32'h0, 32'h0);
    waitIdle();
    requestAndRelease(6'b100011, 16'h0, 32'h0, 32'h0, 32'h0);
    waitIdle();

    // Request while streaming must be dropped and flagged one cycle later.
    requestAndRelease(6'b000101, 16'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    repeat (3) tick();
    i_request_select = 6'b000001;
    @(negedge i_clock);
    checkOutput("droppedNotEarly", {31'b0, o_req_dropped}, 32'h0);
    tick();
    i_request_select = SEL_IDLE;
    @(negedge i_clock);
    checkOutput("droppedPulse", {31'b0, o_req_dropped}, 32'h1);
    tick();
    @(negedge i_clock);
    checkOutput("droppedCleared", {31'b0, o_req_dropped}, 32'h0);
    waitIdle();

    // Request during EOD is dropped; the one right after is served.
    requestAndRelease(6'b000011, 16'h0, 32'h03030303, 32'h0, 32'h0);
    repeat (5) tick();
    i_request_select = 6'b000111;
    @(negedge i_clock);
    checkOutput("eodCycle", {31'b0, o_eod}, 32'h1);
    tick();
    applyStimulus(6'b000010, 16'h0, 32'h02020202, 32'h0, 32'h0, 3, 1'b1);
    @(negedge i_clock);
    checkOutput("eodReqDropped", {31'b0, o_req_dropped}, 32'h1);
    tick();
    i_request_select = SEL_IDLE;
    @(negedge i_clock);
    checkOutput("acceptAfterEod", {31'b0, o_busy}, 32'h1);
    waitIdle();

    // Reset mid-strip aborts without EoD.
    applyStimulus(6'b000101, 16'h0, 32'hDEADBEEF, 32'h0, 32'h0, 2, 1'b0);
    tick();
    i_request_select = SEL_IDLE;
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    @(negedge i_clock);
    checkOutput("abortBusy", {31'b0, o_busy}, 32'h0);
    checkOutput("abortOutputs", {30'b0, o_frame_valid, o_eod}, 32'h0);
    repeat (6) tick();

    checkOutput("scoreboardEmpty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
